// File: rtl/dly_cal_sched.sv
`timescale 1ns/1ps
// Round-robin delay-calibration scheduler: measures a lane's full-period tap count,
// scales it by the lane phase and writes the slave tap when the lane is idle.
// Optional TPRD reuse cache is enabled with `define DLY_CAL_CACHE_EN.
module dly_cal_sched #(
  parameter logic [11:0] TIMEOUT   = 12'd4000,
  parameter logic [15:0] CACHE_AGE = 16'd1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic [7:0] Phase,
  input  logic [3:0] LaneBusy,
  output logic       MeasStart,
  input  logic       MeasDone,
  input  logic [7:0] MeasTPRD,
  output logic [3:0] Gnt,
  output logic [3:0] TapWr,
  output logic [7:0] TapVal,
  output logic [3:0] ToutErr,
  output logic [2:0] SchedState
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_APPLY = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_lane;
  logic [11:0] r_cnt;
  logic [7:0]  r_tprd;
  logic [7:0]  r_tap;
  logic        r_mstart;
  logic [3:0]  r_gnt;
  logic [3:0]  r_tapwr;
  logic [7:0]  r_tapval;
  logic [3:0]  r_tout;
`ifdef DLY_CAL_CACHE_EN
  logic        r_cache_vld;
  logic [7:0]  r_cache_tprd;
  logic [15:0] r_age;
  logic        r_use_cache;
`endif

  logic       w_any;
  logic [1:0] w_win;
  logic [1:0] w_phase;
  logic [9:0] w_prod;
  logic [7:0] w_tap_raw;
  logic [7:0] w_tap;

  // Search starts one past the last winner so every requesting lane gets a turn.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!w_any && Req[2'(r_ptr + 2'(i))]) begin
        w_any = 1'b1;
        w_win = 2'(r_ptr + 2'(i));
      end
    end
  end

  // 255 * 4 = 1020 fits in 10 bits, so the shifted result is at most 255.
  always_comb begin
    w_phase   = Phase[2*r_lane +: 2];
    w_prod    = {2'b00, r_tprd} * ({8'd0, w_phase} + 10'd1);
    w_tap_raw = 8'(w_prod >> 2);
    w_tap     = (w_tap_raw == 8'd0) ? 8'd1 : w_tap_raw;
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values;
  // the cache store is a handful of flops, so it is reset like everything else.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd3;
      r_lane   <= 2'd0;
      r_cnt    <= 12'd0;
      r_tprd   <= 8'd0;
      r_tap    <= 8'd0;
      r_mstart <= 1'b0;
      r_gnt    <= 4'd0;
      r_tapwr  <= 4'd0;
      r_tapval <= 8'd0;
      r_tout   <= 4'd0;
`ifdef DLY_CAL_CACHE_EN
      r_cache_vld  <= 1'b0;
      r_cache_tprd <= 8'd0;
      r_age        <= 16'd0;
      r_use_cache  <= 1'b0;
`endif
    end else begin
      r_mstart <= 1'b0;
      r_gnt    <= 4'd0;
      r_tapwr  <= 4'd0;
`ifdef DLY_CAL_CACHE_EN
      if (r_age != CACHE_AGE) r_age <= r_age + 16'd1;
      else                    r_cache_vld <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_lane  <= w_win;
            r_ptr   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_state <= S_START;
`ifdef DLY_CAL_CACHE_EN
            r_use_cache <= r_cache_vld;
            r_mstart    <= ~r_cache_vld;
`else
            r_mstart <= 1'b1;
`endif
          end
        end
        S_START: begin
`ifdef DLY_CAL_CACHE_EN
          if (r_use_cache) begin
            r_tprd  <= r_cache_tprd;
            r_state <= S_CALC;
          end else begin
            r_cnt   <= 12'd0;
            r_state <= S_WAIT;
          end
`else
          r_cnt   <= 12'd0;
          r_state <= S_WAIT;
`endif
        end
        S_WAIT: begin
          if (MeasDone) begin
            r_tprd  <= MeasTPRD;
            r_state <= S_CALC;
`ifdef DLY_CAL_CACHE_EN
            r_cache_vld  <= 1'b1;
            r_cache_tprd <= MeasTPRD;
            r_age        <= 16'd0;
`endif
          end else if (r_cnt == TIMEOUT - 12'd1) begin
            r_tout[r_lane] <= 1'b1;
            r_state        <= S_IDLE;
`ifdef DLY_CAL_CACHE_EN
            r_cache_vld <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        S_CALC: begin
          r_tap   <= w_tap;
          r_state <= S_APPLY;
        end
        S_APPLY: begin
          if (!LaneBusy[r_lane]) begin
            r_tapwr        <= 4'b0001 << r_lane;
            r_tapval       <= r_tap;
            r_tout[r_lane] <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MeasStart  = r_mstart;
  assign Gnt        = r_gnt;
  assign TapWr      = r_tapwr;
  assign TapVal     = r_tapval;
  assign ToutErr    = r_tout;
  assign SchedState = r_state;

endmodule

// File: tb/tb_dly_cal_sched.sv
`timescale 1ns/1ps
// Directed bench for dly_cal_sched: round robin, tap scaling, busy deferral,
// timeout flags and reset; also covers TPRD reuse when DLY_CAL_CACHE_EN is defined.
module tb_dly_cal_sched;

`ifdef DLY_CAL_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  localparam int CACHE_AGE_TB = 1024;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Req;
  logic [7:0] Phase;
  logic [3:0] LaneBusy;
  logic       MeasStart;
  logic       MeasDone;
  logic [7:0] MeasTPRD;
  logic [3:0] Gnt;
  logic [3:0] TapWr;
  logic [7:0] TapVal;
  logic [3:0] ToutErr;
  logic [2:0] SchedState;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_tapwr  = 0;
  int cyc      = 0;

  // Bench-side view of the TPRD cache (only consulted in the cache build).
  bit         m_vld;
  logic [7:0] m_tprd;
  int         m_cyc;

  dly_cal_sched dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .Phase      (Phase),
    .LaneBusy   (LaneBusy),
    .MeasStart  (MeasStart),
    .MeasDone   (MeasDone),
    .MeasTPRD   (MeasTPRD),
    .Gnt        (Gnt),
    .TapWr      (TapWr),
    .TapVal     (TapVal),
    .ToutErr    (ToutErr),
    .SchedState (SchedState)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (MeasStart)    n_start++;
    if (TapWr != 4'd0) n_tapwr++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    for (int i = 0; i < 8 && SchedState !== s; i++) tick();
    check(tag, SchedState, s);
  endtask

  function automatic logic [7:0] calc_tap(input logic [7:0] t, input logic [1:0] p);
    int v;
    v = (int'(t) * (int'(p) + 1)) / 4;
    return (v == 0) ? 8'd1 : 8'(v);
  endfunction

  task automatic expire_cache();
    if (CACHE_ON) repeat (CACHE_AGE_TB + 80) tick();
  endtask

  // One full calibration of 'lane'; exp_tap is hand-computed for a fresh measurement.
  task automatic do_cal(input logic [3:0] req, input logic [7:0] tprd, input int lane,
                        input bit drop, input int busy, input logic [7:0] exp_tap);
    int         n0s;
    int         n0w;
    bit         cached;
    logic [7:0] tap;
    n0s = n_start;
    n0w = n_tapwr;
    Req = req;
    wait_state(3'd1, $sformatf("cal_start_l%0d", lane));
    cached = CACHE_ON && m_vld && ((cyc - m_cyc) < CACHE_AGE_TB);
    tap    = cached ? calc_tap(m_tprd, Phase[2*lane +: 2]) : exp_tap;
    check($sformatf("cal_gnt_l%0d", lane), Gnt, 4'b0001 << lane);
    check($sformatf("cal_mstart_l%0d", lane), MeasStart, !cached);
    if (drop) Req = 4'd0;
    if (!cached) begin
      tick();
      check("cal_wait", SchedState, 3'd2);
      tick();
      MeasDone = 1'b1;
      MeasTPRD = tprd;
      tick();
      MeasDone = 1'b0;
      MeasTPRD = 8'd0;
      m_vld  = 1'b1;
      m_tprd = tprd;
      m_cyc  = cyc;
    end else begin
      tick();
    end
    check("cal_calc", SchedState, 3'd3);
    LaneBusy[lane] = (busy > 0);
    tick();
    repeat (busy) tick();
    check("cal_apply_hold", SchedState, 3'd4);
    check("cal_no_early_wr", n_tapwr - n0w, 0);
    LaneBusy = 4'd0;
    tick();
    check($sformatf("cal_tapwr_l%0d", lane), TapWr, 4'b0001 << lane);
    check($sformatf("cal_tapval_l%0d", lane), TapVal, tap);
    check("cal_tout_clr", ToutErr[lane], 1'b0);
    check("cal_back_idle", SchedState, 3'd0);
    tick();
    check("cal_tapval_hold", TapVal, tap);
    check("cal_one_mstart", n_start - n0s, cached ? 0 : 1);
  endtask

  task automatic do_tout(input logic [3:0] req, input int lane);
    int n0w;
    int n;
    n0w = n_tapwr;
    n   = 0;
    Req = req;
    wait_state(3'd1, "tout_start");
    check($sformatf("tout_gnt_l%0d", lane), Gnt, 4'b0001 << lane);
    Req = 4'd0;
    tick();
    check("tout_wait", SchedState, 3'd2);
    while (SchedState == 3'd2 && n < 5000) begin
      tick();
      n++;
    end
    check("tout_wait_cycles", n, 4000);
    check("tout_idle", SchedState, 3'd0);
    check($sformatf("tout_flag_l%0d", lane), ToutErr[lane], 1'b1);
    check("tout_no_tapwr", n_tapwr - n0w, 0);
    m_vld = 1'b0;
  endtask

  initial begin
    int n0s;
    int n0w;
    Reset    = 1'b1;
    Req      = 4'd0;
    Phase    = 8'd0;
    LaneBusy = 4'd0;
    MeasDone = 1'b0;
    MeasTPRD = 8'd0;
    m_vld    = 1'b0;
    m_tprd   = 8'd0;
    m_cyc    = 0;
    repeat (3) tick();
    check("rst_state", SchedState, 3'd0);
    check("rst_gnt", Gnt, 4'd0);
    check("rst_mstart", MeasStart, 1'b0);
    check("rst_tapwr", TapWr, 4'd0);
    check("rst_tapval", TapVal, 8'd0);
    check("rst_tout", ToutErr, 4'd0);
    Reset = 1'b0;
    tick();

    // Round robin with Req held: lanes 0, 1, 3, then 0 again.
    Phase = 8'b11_00_01_00;
    do_cal(4'b1011, 8'd120, 0, 1'b0, 0, 8'd30);   // 120*1/4
    do_cal(4'b1011, 8'd7,   1, 1'b0, 0, 8'd3);    // 7*2/4 = 3
    do_cal(4'b1011, 8'd255, 3, 1'b0, 0, 8'd255);  // 255*4/4
    do_cal(4'b1011, 8'd3,   0, 1'b1, 0, 8'd1);    // 3/4 = 0 forced to 1

    // Single request, 180 degrees, TPRD 100 -> 50.
    Phase = 8'b11_00_01_01;
    do_cal(4'b0001, 8'd100, 0, 1'b1, 0, 8'd50);

    // Stray MeasDone in IDLE does nothing.
    n0w = n_tapwr;
    MeasDone = 1'b1;
    MeasTPRD = 8'hAA;
    tick();
    MeasDone = 1'b0;
    MeasTPRD = 8'd0;
    tick();
    check("stray_done_idle", SchedState, 3'd0);
    check("stray_done_tapval", TapVal, 8'd50);
    check("stray_done_no_wr", n_tapwr - n0w, 0);

    // Lane 2 busy for 20 APPLY cycles; TPRD 1 at 90 degrees -> 1.
    do_cal(4'b0100, 8'd1, 2, 1'b1, 20, 8'd1);

    // Timeout on lane 1, then a good calibration clears the flag (270 deg: 40*3/4 = 30).
    expire_cache();
    do_tout(4'b0010, 1);
    check("tout_only_l1", ToutErr, 4'b0010);
    Phase = 8'b11_00_10_01;
    do_cal(4'b0010, 8'd40, 1, 1'b1, 0, 8'd30);
    check("tout_cleared", ToutErr, 4'd0);

    // Timeout on lane 3, then reset in mid-measurement clears everything.
    expire_cache();
    do_tout(4'b1000, 3);
    check("tout_only_l3", ToutErr, 4'b1000);
    Req = 4'b0001;
    wait_state(3'd1, "rst_mid_start");
    Req = 4'd0;
    tick();
    check("rst_mid_wait", SchedState, 3'd2);
    tick();
    Reset = 1'b1;
    #1;
    check("arst_state", SchedState, 3'd0);
    check("arst_tapval", TapVal, 8'd0);
    check("arst_tout", ToutErr, 4'd0);
    check("arst_gnt", Gnt, 4'd0);
    tick();
    Reset = 1'b0;
    m_vld = 1'b0;
    n0s = n_start;
    n0w = n_tapwr;
    tick();
    MeasDone = 1'b1;
    MeasTPRD = 8'd77;
    tick();
    MeasDone = 1'b0;
    MeasTPRD = 8'd0;
    repeat (3) tick();
    check("late_done_idle", SchedState, 3'd0);
    check("late_done_tapval", TapVal, 8'd0);
    check("late_done_outs", {Gnt, TapWr, ToutErr, 3'd0, MeasStart}, 16'd0);
    check("late_done_no_wr", n_tapwr - n0w, 0);
    check("late_done_no_start", n_start - n0s, 0);

    // Pointer back at 3 after reset: lane 0 beats lane 1 (180 deg: 200*2/4 = 100).
    do_cal(4'b0011, 8'd200, 0, 1'b1, 0, 8'd100);
    // Immediate re-request; reuses TPRD 200 when the cache is built in.
    do_cal(4'b0001, 8'd60, 0, 1'b1, 0, 8'd30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
